conv_psum_buffer: RTL and testbench

- Partial-sum / output-feature-map buffer at the output end of a convolution datapath.
- Captures each output word the datapath produces (data_out_for_next).
- On later depth passes, returns the previously stored partial sum for the same output pixel, to feed the datapath's data_in_from_next.
- After the final pass, the next layer drains the completed OFM sequentially through a read port.

---
 rtl/conv_psum_pkg.sv | 27 ++
 rtl/conv_psum_buffer_if.sv | 28 ++
 rtl/ofm_dual_port_ram.sv | 30 +++
 rtl/conv_psum_buffer.sv | 150 +++++++++++++++
 tb/tb_conv_psum_buffer.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/conv_psum_pkg.sv
// Shared types and sizing helpers for the conv partial-sum buffer.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package conv_psum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Depth passes needed to consume every input channel.
    function automatic int num_passes(input int ifm_depth, input int number_of_units);
        return (ifm_depth + number_of_units - 1) / number_of_units;
    endfunction

    // One word per output pixel per filter.
    function automatic int total_words(input int ifm_size_next, input int number_of_filters);
        return ifm_size_next * ifm_size_next * number_of_filters;
    endfunction

    // Address width, never below one bit.
    function automatic int addr_w(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/conv_psum_buffer_if.sv
// Handshake and data bundle between the conv datapath/next layer and the psum buffer.
// Latency: n/a (wiring only).
// Backpressure: none; the buffer flags protocol misuse through err.
interface conv_psum_buffer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] data_in_from_previous;
    logic                  psum_rd_en;
    logic [DATA_WIDTH-1:0] data_out_for_previous;
    logic                  drain_rd_en;
    logic [DATA_WIDTH-1:0] drain_data;
    logic                  drain_valid;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        output start, wr_en, data_in_from_previous, psum_rd_en, drain_rd_en,
        input  data_out_for_previous, drain_data, drain_valid, busy, done, err
    );

    modport slave (
        input  start, wr_en, data_in_from_previous, psum_rd_en, drain_rd_en,
        output data_out_for_previous, drain_data, drain_valid, busy, done, err
    );
endinterface

// File: rtl/ofm_dual_port_ram.sv
// Simple dual-port OFM storage: one write port, one registered read port.
// Latency: read data 1 cycle after re; a same-cycle write to raddr returns the old word.
// Backpressure: none; always accepts.
module ofm_dual_port_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Registered read; sampling the array before the write lands gives read-before-write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)   rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/conv_psum_buffer.sv
// Partial-sum / OFM buffer: stores datapath words, replays them on later depth passes, drains the final OFM.
// Latency: psum and drain reads return 1 cycle after the request.
// Backpressure: none; illegal or excess requests are dropped and latch the sticky err flag.
module conv_psum_buffer
    import conv_psum_pkg::*;
#(
    parameter int DATA_WIDTH        = 32,
    parameter int IFM_SIZE_NEXT     = 28,
    parameter int NUMBER_OF_FILTERS = 6,
    parameter int IFM_DEPTH         = 3,
    parameter int NUMBER_OF_UNITS   = 3
) (
    input  logic             clk,
    input  logic             reset,
    conv_psum_buffer_if.slave bus
);
    localparam int NUM_PASSES  = num_passes(IFM_DEPTH, NUMBER_OF_UNITS);
    localparam int TOTAL_WORDS = total_words(IFM_SIZE_NEXT, NUMBER_OF_FILTERS);
    localparam int ADDR_W      = addr_w(TOTAL_WORDS);
    // One extra bit so the psum read counter can sit at TOTAL_WORDS (saturated).
    localparam int CNT_W       = ADDR_W + 1;
    localparam int PASS_W      = addr_w(NUM_PASSES + 1);

    localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(TOTAL_WORDS - 1);
    localparam logic [CNT_W-1:0]  FULL      = CNT_W'(TOTAL_WORDS);
    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NUM_PASSES - 1);

    state_t                state, state_nxt;
    logic [PASS_W-1:0]     pass;
    logic [CNT_W-1:0]      wr_addr, rd_addr, drain_addr;
    logic                  wr_go, psum_go, drain_go, wr_wrap, drain_last, err_evt;
    logic                  psum_take, psum_zero, drain_valid_q, done_q, err_q;
    logic [DATA_WIDTH-1:0] psum_hold, psum_val, ram_q;
    logic [ADDR_W-1:0]     ram_raddr;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state, accepted operations and protocol violations.
    always_comb begin
        state_nxt  = state;
        wr_go      = 1'b0;
        psum_go    = 1'b0;
        drain_go   = 1'b0;
        wr_wrap    = 1'b0;
        drain_last = 1'b0;
        err_evt    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) state_nxt = ACCUM;
                err_evt = bus.wr_en | bus.psum_rd_en | bus.drain_rd_en;
            end
            ACCUM: begin
                wr_go   = bus.wr_en;
                psum_go = bus.psum_rd_en && (rd_addr != FULL);
                wr_wrap = wr_go && (wr_addr == LAST_WORD);
                if (wr_wrap && (pass == LAST_PASS)) state_nxt = DRAIN;
                err_evt = bus.start | bus.drain_rd_en | (bus.psum_rd_en && (rd_addr == FULL));
            end
            DRAIN: begin
                drain_go   = bus.drain_rd_en;
                drain_last = drain_go && (drain_addr == LAST_WORD);
                if (drain_last) state_nxt = IDLE;
                err_evt = bus.start | bus.wr_en | bus.psum_rd_en;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pass and address counters; a wrapping write restarts both address streams.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pass       <= '0;
            wr_addr    <= '0;
            rd_addr    <= '0;
            drain_addr <= '0;
        end else begin
            if (state == IDLE && bus.start) begin
                pass    <= '0;
                wr_addr <= '0;
                rd_addr <= '0;
            end
            if (psum_go) rd_addr <= rd_addr + 1'b1;
            if (wr_go) begin
                if (wr_wrap) begin
                    wr_addr <= '0;
                    rd_addr <= '0;
                    pass    <= pass + 1'b1;
                end else begin
                    wr_addr <= wr_addr + 1'b1;
                end
            end
            if (wr_wrap && (pass == LAST_PASS)) drain_addr <= '0;
            if (drain_go) drain_addr <= drain_addr + 1'b1;
        end
    end

    // The RAM read port is shared; only one of the two readers is legal per state.
    assign ram_raddr = (state == DRAIN) ? drain_addr[ADDR_W-1:0] : rd_addr[ADDR_W-1:0];

    ofm_dual_port_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (TOTAL_WORDS),
        .ADDR_W     (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (wr_go),
        .waddr (wr_addr[ADDR_W-1:0]),
        .wdata (bus.data_in_from_previous),
        .re    (psum_go | drain_go),
        .raddr (ram_raddr),
        .rdata (ram_q)
    );

    // Read-side tracking: which reader owns ram_q this cycle, held psum value, done and err.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            psum_take     <= 1'b0;
            psum_zero     <= 1'b0;
            psum_hold     <= '0;
            drain_valid_q <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            psum_take     <= psum_go;
            psum_zero     <= (pass == '0);
            psum_hold     <= psum_val;
            drain_valid_q <= drain_go;
            done_q        <= drain_last;
            err_q         <= err_q | err_evt;
        end
    end

    // First pass has no valid history in the RAM, so its psums are zero; otherwise hold between reads.
    always_comb begin
        psum_val = psum_hold;
        if (psum_take) psum_val = psum_zero ? '0 : ram_q;
    end

    assign bus.data_out_for_previous = psum_val;
    assign bus.drain_data            = drain_valid_q ? ram_q : '0;
    assign bus.drain_valid           = drain_valid_q;
    assign bus.busy                  = (state != IDLE);
    assign bus.done                  = done_q;
    assign bus.err                   = err_q;
endmodule

// File: tb/tb_conv_psum_buffer.sv
// Directed plus randomized bench for conv_psum_buffer (8-word buffer, two depth passes).
// Latency: checks outputs 1 time unit after each rising edge.
// Backpressure: exercises dropped/illegal requests and the sticky err flag.
module tb_conv_psum_buffer;
    localparam int DW = 32;
    localparam int N  = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    conv_psum_buffer_if #(.DATA_WIDTH(DW)) bus();

    conv_psum_buffer #(
        .DATA_WIDTH        (DW),
        .IFM_SIZE_NEXT     (2),
        .NUMBER_OF_FILTERS (2),
        .IFM_DEPTH         (6),
        .NUMBER_OF_UNITS   (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] ref_mem [N];
    logic [DW-1:0] last_psum;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        bus.data_in_from_previous = '0;
        bus.psum_rd_en = 1'b0;
        bus.drain_rd_en = 1'b0;
    endtask

    task automatic psum_read(input string tag, input logic [DW-1:0] exp);
        bus.psum_rd_en = 1'b1;
        cycle();
        bus.psum_rd_en = 1'b0;
        chk(tag, bus.data_out_for_previous, exp);
    endtask

    task automatic write_word(input int addr, input logic [DW-1:0] d);
        bus.wr_en = 1'b1;
        bus.data_in_from_previous = d;
        cycle();
        bus.wr_en = 1'b0;
        ref_mem[addr] = d;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_psum"}, bus.data_out_for_previous, '0);
        chk({tag, "_dvalid"}, {31'd0, bus.drain_valid}, '0);
        chk({tag, "_ddata"}, bus.drain_data, '0);
        chk({tag, "_busy"}, {31'd0, bus.busy}, '0);
        chk({tag, "_done"}, {31'd0, bus.done}, '0);
        chk({tag, "_err"}, {31'd0, bus.err}, '0);
    endtask

    initial begin
        int got, issued, budget, mode;
        logic req_prev;
        logic [DW-1:0] d, exp_word;

        clear_inputs();
        reset = 1'b1;
        repeat (2) cycle();
        check_all_zero("reset");
        reset = 1'b0;
        cycle();

        // Write in IDLE is flagged and ignored.
        bus.wr_en = 1'b1;
        bus.data_in_from_previous = 32'd999;
        cycle();
        bus.wr_en = 1'b0;
        chk("idle_wr_err", {31'd0, bus.err}, 32'd1);
        chk("idle_wr_busy", {31'd0, bus.busy}, 32'd0);

        // Pass 0: every psum reads as zero; a stray start mid-pass is ignored.
        do_start();
        chk("start_busy", {31'd0, bus.busy}, 32'd1);
        for (int i = 0; i < N; i++) begin
            if (i == 4) begin
                do_start();
                chk("start_in_accum_err", {31'd0, bus.err}, 32'd1);
                chk("start_in_accum_busy", {31'd0, bus.busy}, 32'd1);
            end
            psum_read($sformatf("p0_psum%0d", i), 32'd0);
            write_word(i, 32'(10 + i));
        end
        chk("p0_end_busy", {31'd0, bus.busy}, 32'd1);

        // Pass 1: read back 10..17, collision at address 3 returns the old word.
        for (int i = 0; i < N; i++) begin
            if (i == 3) begin
                bus.psum_rd_en = 1'b1;
                bus.wr_en = 1'b1;
                bus.data_in_from_previous = 32'd555;
                cycle();
                clear_inputs();
                chk("collision_old", bus.data_out_for_previous, 32'd13);
                ref_mem[3] = 32'd555;
            end else begin
                psum_read($sformatf("p1_psum%0d", i), 32'(10 + i));
                write_word(i, 32'(100 + i));
            end
        end
        chk("p1_end_busy", {31'd0, bus.busy}, 32'd1);

        // Drain with drain_rd_en held for 8 cycles.
        bus.drain_rd_en = 1'b1;
        for (int i = 0; i < N; i++) begin
            cycle();
            if (i == N - 1) bus.drain_rd_en = 1'b0;
            exp_word = (i == 3) ? 32'd555 : 32'(100 + i);
            chk($sformatf("drain_valid%0d", i), {31'd0, bus.drain_valid}, 32'd1);
            chk($sformatf("drain_data%0d", i), bus.drain_data, exp_word);
            chk($sformatf("drain_done%0d", i), {31'd0, bus.done}, (i == N - 1) ? 32'd1 : 32'd0);
        end
        cycle();
        chk("post_drain_valid", {31'd0, bus.drain_valid}, 32'd0);
        chk("post_drain_done", {31'd0, bus.done}, 32'd0);
        chk("post_drain_busy", {31'd0, bus.busy}, 32'd0);

        // Reset clears the sticky err.
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();
        chk("err_cleared", {31'd0, bus.err}, 32'd0);

        // Randomized layer checked against the array model.
        do_start();
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(1, 0) == 1) psum_read($sformatf("rp0_psum%0d", i), 32'd0);
            write_word(i, $urandom);
        end
        for (int i = 0; i < N; i++) begin
            d = $urandom;
            mode = (i == N - 1) ? 0 : int'($urandom_range(2, 0));
            exp_word = ref_mem[i];
            if (mode == 1) begin
                bus.psum_rd_en = 1'b1;
                bus.wr_en = 1'b1;
                bus.data_in_from_previous = d;
                cycle();
                clear_inputs();
                chk($sformatf("rp1_coll%0d", i), bus.data_out_for_previous, exp_word);
                ref_mem[i] = d;
            end else begin
                psum_read($sformatf("rp1_psum%0d", i), exp_word);
                last_psum = exp_word;
                if (mode == 2) begin
                    cycle();
                    chk($sformatf("rp1_hold%0d", i), bus.data_out_for_previous, last_psum);
                end
                if (i == N - 1) begin
                    // Ninth read in a pass is dropped and flagged; output keeps its value.
                    chk("rp1_err_before_sat", {31'd0, bus.err}, 32'd0);
                    bus.psum_rd_en = 1'b1;
                    cycle();
                    bus.psum_rd_en = 1'b0;
                    chk("rp1_sat_err", {31'd0, bus.err}, 32'd1);
                    chk("rp1_sat_hold", bus.data_out_for_previous, last_psum);
                end
                write_word(i, d);
            end
        end

        // Drain with random request gaps.
        got = 0;
        issued = 0;
        budget = 0;
        while (got < N && budget < 200) begin
            bus.drain_rd_en = (issued < N) && ($urandom_range(1, 0) == 1);
            req_prev = bus.drain_rd_en;
            if (req_prev) issued++;
            cycle();
            budget++;
            chk("rdrain_valid", {31'd0, bus.drain_valid}, {31'd0, req_prev});
            if (bus.drain_valid && got < N) begin
                chk($sformatf("rdrain_data%0d", got), bus.drain_data, ref_mem[got]);
                chk($sformatf("rdrain_done%0d", got), {31'd0, bus.done}, (got == N - 1) ? 32'd1 : 32'd0);
                got++;
            end
        end
        bus.drain_rd_en = 1'b0;
        chk("rdrain_count", 32'(got), 32'(N));
        cycle();
        chk("rdrain_busy", {31'd0, bus.busy}, 32'd0);

        // Reset in the middle of pass 1, then a clean restart at pass 0.
        do_start();
        for (int i = 0; i < N; i++) write_word(i, 32'(200 + i));
        for (int i = 0; i < 4; i++) write_word(i, 32'(300 + i));
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        cycle();
        reset = 1'b0;
        cycle();
        do_start();
        for (int i = 0; i < N; i++) psum_read($sformatf("restart_psum%0d", i), 32'd0);
        chk("restart_busy", {31'd0, bus.busy}, 32'd1);
        chk("restart_err", {31'd0, bus.err}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
